mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_pick2.sv | 31 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester single-port RAM arbiter: FSM states, requester ids, default widths.
// The MEM_ARB_RR_EN build uses other_id() to hand a conflict to the requester that did not win last.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 10;
  localparam int MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } req_id_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == CPU) ? LDR : CPU;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select between the CPU data port and the program loader.
// MEM_ARB_RR_EN defined: round-robin against the last winner; otherwise CPU has fixed priority.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    ldr_req_i,
`ifdef MEM_ARB_RR_EN
  input  req_id_e last_i,
`endif
  output logic    vld_o,
  output req_id_e win_o
);

  always_comb begin
    vld_o = cpu_req_i | ldr_req_i;
    win_o = CPU;
`ifdef MEM_ARB_RR_EN
    if (cpu_req_i && ldr_req_i) begin
      win_o = other_id(last_i);
    end else if (ldr_req_i) begin
      win_o = LDR;
    end
`else
    if (!cpu_req_i && ldr_req_i) begin
      win_o = LDR;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and loader onto one registered single-port RAM: gnt at t, RAM strobe at t+1, read data at t+3.
// Policy set by MEM_ARB_RR_EN (round-robin) vs default fixed CPU priority; timing is identical in both builds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              cpu_gnt,
  output logic              ldr_gnt,
  output logic              cpu_rvalid,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              win_vld;
  req_id_e           win_id;
  logic              grant;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  req_id_e           owner_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef MEM_ARB_RR_EN
  req_id_e           last_q;
`endif

  arb_pick2 u_pick (
    .cpu_req_i (cpu_req),
    .ldr_req_i (ldr_req),
`ifdef MEM_ARB_RR_EN
    .last_i    (last_q),
`endif
    .vld_o     (win_vld),
    .win_o     (win_id)
  );

  // Requests seen while reset is high must never be granted.
  assign grant = (state_q == IDLE) && win_vld && !reset;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    busy       = 1'b0;
    cpu_rvalid = 1'b0;
    ldr_rvalid = 1'b0;
    if (!reset) begin
      cpu_gnt    = grant && (win_id == CPU);
      ldr_gnt    = grant && (win_id == LDR);
      busy       = (state_q != IDLE);
      cpu_rvalid = rvalid_q && (owner_q == CPU);
      ldr_rvalid = rvalid_q && (owner_q == LDR);
      if (state_q == ACCESS) begin
        ram_we = we_q;
        ram_re = !we_q;
      end
    end
  end

  // Request fields are only captured in the grant cycle.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (grant) begin
      we_d    = (win_id == CPU) ? cpu_we    : ldr_we;
      addr_d  = (win_id == CPU) ? cpu_addr  : ldr_addr;
      wdata_d = (win_id == CPU) ? cpu_wdata : ldr_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner_q  <= LDR;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= (state_q == RDWAIT);
      if (grant) begin
        owner_q <= win_id;
      end
      if (state_q == RDWAIT) begin
        rdata_q <= ram_rdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      last_q <= LDR;
    end else if (grant) begin
      last_q <= win_id;
    end
  end
`endif

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a per-cycle reference of grants/strobes/rvalid plus a shadow memory for read data.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            cyc;
    bit            id;
    logic [DW-1:0] data;
  } rv_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, ldr_req = 1'b0;
  logic          cpu_we = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_re, busy;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  op_t  cpu_q[$], ldr_q[$];
  cmd_t cmd_q[$];
  rv_t  rv_q[$];
  bit   gseq[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  int   m_free = 0;
  int   m_gnt = 0;
  bit   m_last = 1'b1;
  logic [DW-1:0] m_rdata = '0;

  logic [6:0] m_act, m_exp;
  op_t  g_op;
  bit   g_id;
  cmd_t g_cmd;
  rv_t  g_rv;

  mem_arbiter dut (
    .CLK        (CLK),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .cpu_gnt    (cpu_gnt),
    .ldr_gnt    (ldr_gnt),
    .cpu_rvalid (cpu_rvalid),
    .ldr_rvalid (ldr_rvalid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Registered single-port RAM environment.
  always @(posedge CLK) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Requesters: hold req while an op is pending; real fields only when a grant is possible, junk otherwise.
  always @(posedge CLK) begin
    #1;
    cpu_req = (cpu_q.size() > 0);
    ldr_req = (ldr_q.size() > 0);
    if (cpu_req && cyc >= m_free) begin
      cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
    end else begin
      cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = $urandom;
    end
    if (ldr_req && cyc >= m_free) begin
      ldr_we = ldr_q[0].we; ldr_addr = ldr_q[0].addr; ldr_wdata = ldr_q[0].wdata;
    end else begin
      ldr_we = 1'($urandom); ldr_addr = AW'($urandom); ldr_wdata = $urandom;
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge CLK) begin
    m_act = {cpu_gnt, ldr_gnt, ram_we, ram_re, busy, cpu_rvalid, ldr_rvalid};
    if (cpu_gnt) gseq.push_back(1'b0);
    if (ldr_gnt) gseq.push_back(1'b1);
    if (reset) begin
      started = 1'b1;
      check_eq("rst_ctl", 64'(m_act), 64'd0);
      cmd_q.delete();
      rv_q.delete();
      m_last  = 1'b1;
      m_free  = cyc + 1;
      m_gnt   = cyc;
      m_rdata = '0;
    end else if (started) begin
      m_exp = '0;
      if (cyc >= m_free && (cpu_req || ldr_req)) begin
`ifdef MEM_ARB_RR_EN
        if (cpu_req && ldr_req) g_id = !m_last;
        else g_id = !cpu_req;
`else
        g_id = !cpu_req;
`endif
        if (g_id) begin
          g_op = ldr_q.pop_front();
          m_exp[5] = 1'b1;
        end else begin
          g_op = cpu_q.pop_front();
          m_exp[6] = 1'b1;
        end
        g_cmd = '{cyc: cyc + 1, we: g_op.we, addr: g_op.addr, wdata: g_op.wdata};
        cmd_q.push_back(g_cmd);
        if (g_op.we) begin
          ref_mem[g_op.addr] = g_op.wdata;
          m_free = cyc + 2;
        end else begin
          g_rv = '{cyc: cyc + 3, id: g_id, data: ref_mem[g_op.addr]};
          rv_q.push_back(g_rv);
          m_free = cyc + 3;
        end
        m_gnt  = cyc;
        m_last = g_id;
      end
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        g_cmd = cmd_q.pop_front();
        m_exp[4] = g_cmd.we;
        m_exp[3] = !g_cmd.we;
        check_eq("ram_addr", 64'(ram_addr), 64'(g_cmd.addr));
        if (g_cmd.we) check_eq("ram_wdata", 64'(ram_wdata), 64'(g_cmd.wdata));
      end
      if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
        g_rv = rv_q.pop_front();
        if (g_rv.id) m_exp[0] = 1'b1;
        else m_exp[1] = 1'b1;
        m_rdata = g_rv.data;
      end
      m_exp[2] = (cyc > m_gnt) && (cyc < m_free);
      check_eq("ctl{cg,lg,we,re,busy,crv,lrv}", 64'(m_act), 64'(m_exp));
      check_eq("rdata", 64'(rdata), 64'(m_rdata));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (cpu_q.size() == 0 && ldr_q.size() == 0 && cmd_q.size() == 0 &&
          rv_q.size() == 0 && cyc >= m_free) return;
    end
    check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_gnt(input bit id, output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (id ? ldr_gnt : cpu_gnt) begin
        at = cyc;
        return;
      end
    end
    check_eq("gnt_timeout", 64'd1, 64'd0);
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  initial begin
    int t_c, t_l;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    // Request pending through reset must wait for deassertion.
    cpu_q.push_back(mk(1'b1, 10'h010, 32'h1234_5678));
    repeat (4) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check_eq("post_rst_rdata", 64'(rdata), 64'd0);
    wait_idle();

    // Write then read back address 0x004.
    cpu_q.push_back(mk(1'b1, 10'h004, 32'hDEAD_BEEF));
    wait_idle();
    cpu_q.push_back(mk(1'b0, 10'h004, 32'h0));
    wait_idle();
    check_eq("rd004_rdata", 64'(rdata), 64'hDEAD_BEEF);

    // Loader arrives during a CPU read: granted exactly in the rvalid cycle.
    cpu_q.push_back(mk(1'b0, 10'h004, 32'h0));
    wait_gnt(1'b0, t_c);
    #1 ldr_q.push_back(mk(1'b1, 10'h020, 32'h0BAD_F00D));
    wait_gnt(1'b1, t_l);
    check_eq("ldr_gnt_delay", 64'(t_l - t_c), 64'd3);
    check_eq("ldr_gnt_with_rvalid", 64'(cpu_rvalid), 64'd1);
    wait_idle();

    // Both request continuously.
    gseq.delete();
    for (int i = 0; i < 6; i++) begin
      cpu_q.push_back(mk(1'(i & 1), AW'(64 + i), 32'hC000_0000 + i));
      ldr_q.push_back(mk(1'(~i & 1), AW'(96 + i), 32'hA000_0000 + i));
    end
    wait_idle();
    check_eq("both_gnt_count", 64'(gseq.size()), 64'd12);
    for (int i = 0; i < 12 && i < gseq.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      check_eq("rr_order", 64'(gseq[i]), 64'(i & 1));
`else
      check_eq("fixed_order", 64'(gseq[i]), 64'(i >= 6));
`endif
    end

    // Top-of-range address.
    ldr_q.push_back(mk(1'b1, 10'h3FF, 32'hA5A5_5A5A));
    ldr_q.push_back(mk(1'b0, 10'h3FF, 32'h0));
    wait_idle();
    check_eq("rd3ff_rdata", 64'(rdata), 64'hA5A5_5A5A);

    // Reset during RDWAIT aborts the read.
    cpu_q.push_back(mk(1'b0, 10'h3FF, 32'h0));
    wait_gnt(1'b0, t_c);
    @(posedge CLK);
    @(posedge CLK); #1 reset = 1'b1;
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    check_eq("abort_rvalid", 64'(cpu_rvalid), 64'd0);
    check_eq("abort_rdata", 64'(rdata), 64'd0);
    wait_idle();

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) cpu_q.push_back(mk(1'($urandom), AW'($urandom), $urandom));
      if ($urandom_range(0, 2) != 0) ldr_q.push_back(mk(1'($urandom), AW'($urandom), $urandom));
      repeat ($urandom_range(0, 4)) @(negedge CLK);
      #1;
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
